// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the op encodings, the FSM state enum and the iteration counter width.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the EX stage and the mul/div unit.
// master = EX stage / hazard logic side, slave = muldiv_unit.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the mul/div datapath.
// Multiply: acc = {partial product, remaining multiplier bits}; shift-add.
// Divide:   acc = {partial remainder, remaining dividend bits}; restore-subtract.
// For divide the lsb of acc_next is left clear; the caller shifts in q_bit.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem;

    // Single radix-2 step: add-then-shift-right for multiply, shift-then-trial-subtract for divide.
    always_comb begin
        sum      = '0;
        partial  = '0;
        trial    = '0;
        rem      = '0;
        acc_next = '0;
        q_bit    = 1'b0;
        if (!div_mode) begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            partial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            trial   = partial - {1'b0, operand};
            if (partial >= {1'b0, operand}) begin
                q_bit = 1'b1;
                rem   = trial[WIDTH-1:0];
            end else begin
                rem   = partial[WIDTH-1:0];
            end
            acc_next = {rem, acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Signed ops run on magnitudes and are sign-corrected in the FIX state.
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero-operand multiply and
// divide-by-zero skip RUN and finish one edge after issue).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int            CW         = count_width(WIDTH);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   raw_a;
    logic               div_mode;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_zero;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_mul;
    logic               is_div;
    logic               is_md;
    logic               is_mt;
    logic               is_signed;
    logic               early_out;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic               accept_md;
    logic               accept_mt;
    logic               do_step;
    logic               do_fix;

    logic [2*WIDTH-1:0] step_next;
    logic               step_q;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign is_mul    = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
    assign is_div    = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
    assign is_md     = is_mul || is_div;
    assign is_mt     = (bus.op == MD_MTHI) || (bus.op == MD_MTLO);
    assign is_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    assign abs_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = (is_mul && ((bus.a == '0) || (bus.b == '0))) || (is_div && (bus.b == '0));
`else
    assign early_out = 1'b0;
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .operand  (operand),
        .div_mode (div_mode),
        .acc_next (step_next),
        .q_bit    (step_q)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-edge actions; cancel always beats start and result write.
    always_comb begin
        state_next = state;
        accept_md  = 1'b0;
        accept_mt  = 1'b0;
        do_step    = 1'b0;
        do_fix     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    if (is_md) begin
                        accept_md  = 1'b1;
                        state_next = early_out ? FIX : RUN;
                    end else if (is_mt) begin
                        accept_mt  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_next = IDLE;
                end else begin
                    do_step = 1'b1;
                    if (count == COUNT_ONE) begin
                        state_next = FIX;
                    end
                end
            end
            FIX: begin
                state_next = IDLE;
                do_fix     = !bus.cancel;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sign correction; divide-by-zero result overrides it entirely.
    always_comb begin
        product = neg_lo ? -acc : acc;
        quot    = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        if (div_mode) begin
            fix_lo = div_zero ? '1    : (neg_lo ? -quot : quot);
            fix_hi = div_zero ? raw_a : (neg_hi ? -rem  : rem);
        end else begin
            fix_lo = product[WIDTH-1:0];
            fix_hi = product[2*WIDTH-1:WIDTH];
        end
    end

    // Operand capture, iteration, HI/LO writes and the registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            raw_a    <= '0;
            div_mode <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= do_fix || accept_mt;
            if (accept_md) begin
                acc      <= (is_mul && early_out) ? '0 : {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                operand  <= is_div ? abs_b : abs_a;
                raw_a    <= bus.a;
                div_mode <= is_div;
                neg_lo   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_hi   <= is_signed && is_div && bus.a[WIDTH-1];
                div_zero <= is_div && (bus.b == '0);
                count    <= COUNT_LOAD;
            end else if (do_step) begin
                acc   <= div_mode ? {step_next[2*WIDTH-1:1], step_q} : step_next;
                count <= count - COUNT_ONE;
            end
            if (accept_mt) begin
                if (bus.op == MD_MTHI) begin
                    hi_q <= bus.a;
                end else begin
                    lo_q <= bus.a;
                end
            end
            if (do_fix) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH = 32).
// Results are predicted with plain 64-bit arithmetic and a HI/LO shadow.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_hi;
    logic [31:0] model_lo;

    // Architectural result of one op given the current HI/LO contents: {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi_in,
                                               input logic [31:0] lo_in);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MD_MULT: begin
                p = sa * sb;
                return p;
            end
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MD_MTHI: return {a, lo_in};
            MD_MTLO: return {hi_in, a};
            default: return {hi_in, lo_in};
        endcase
    endfunction

    // Edges from issue to done (equals the number of busy cycles as well).
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == MD_MTHI || op == MD_MTLO) return 0;
`ifdef MULDIV_EARLY_OUT_EN
        if ((op == MD_MULT || op == MD_MULTU) && (a == 0 || b == 0)) return 1;
        if ((op == MD_DIV || op == MD_DIVU) && b == 0) return 1;
`endif
        return WIDTH + 1;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and wait (bounded) for done; returns edges-to-done and busy cycles.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 3'b000;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        vectors++;
        if (bus.hi !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
        vectors++;
        if (bus.lo !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
        @(negedge clk);
        rst      = 1'b0;
        model_hi = '0;
        model_lo = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [5];
        logic [31:0] t_a  [5];
        logic [31:0] t_b  [5];
        logic [31:0] t_hi [5];
        logic [31:0] t_lo [5];
        int lat, bc, el;
        t_op = '{MD_MULTU, MD_MULT, MD_DIV, MD_DIV, MD_DIVU};
        t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
        t_b  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
        t_hi = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd5};
        t_lo = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            el = exp_lat(t_op[i], t_a[i], t_b[i]);
            issue(t_op[i], t_a[i], t_b[i], lat, bc);
            model_hi = t_hi[i];
            model_lo = t_lo[i];
            vectors++;
            if (bus.hi !== t_hi[i]) begin miscompares++; $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, bus.hi, t_hi[i]); end
            vectors++;
            if (bus.lo !== t_lo[i]) begin miscompares++; $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, bus.lo, t_lo[i]); end
            vectors++;
            if (lat != el) begin miscompares++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, el); end
            vectors++;
            if (bc != el) begin miscompares++; $display("[TB] FAIL directed%0d_busy_cycles: got %0d expected %0d", i, bc, el); end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL directed%0d_done_width: got %b expected 0", i, bus.done); end
        end
    endtask

    task automatic test_mt_cancel();
        int lat, bc;
        bit saw_done;
        issue(MD_MTHI, 32'h1234, 32'h0, lat, bc);
        vectors++;
        if (bc != 0 || lat != 0) begin miscompares++; $display("[TB] FAIL mthi_timing: got lat %0d busy %0d expected 0 0", lat, bc); end
        issue(MD_MTLO, 32'h5678, 32'h0, lat, bc);
        model_hi = 32'h1234;
        model_lo = 32'h5678;
        vectors++;
        if (bus.hi !== 32'h1234) begin miscompares++; $display("[TB] FAIL mthi_value: got %h expected 00001234", bus.hi); end
        vectors++;
        if (bus.lo !== 32'h5678) begin miscompares++; $display("[TB] FAIL mtlo_value: got %h expected 00005678", bus.lo); end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL cancel_busy_before: got %b expected 1", bus.busy); end
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_busy_after: got %b expected 0", bus.busy); end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_no_done: got %b expected 0", saw_done); end
        vectors++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
            miscompares++;
            $display("[TB] FAIL cancel_hilo: got %h/%h expected 00001234/00005678", bus.hi, bus.lo);
        end
    endtask

    task automatic test_drop_start();
        int lat;
        bit saw_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == 4) begin
                bus.start = 1'b1;
                bus.op    = MD_DIVU;
                bus.a     = 32'd100;
                bus.b     = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        model_hi  = 32'h0;
        model_lo  = 32'd42;
        vectors++;
        if (lat != WIDTH + 1) begin miscompares++; $display("[TB] FAIL drop_latency: got %0d expected %0d", lat, WIDTH + 1); end
        vectors++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
            miscompares++;
            $display("[TB] FAIL drop_result: got %h/%h expected 00000000/0000002a", bus.hi, bus.lo);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_not_queued: got %b expected 0", saw_done); end
        // start together with cancel while idle must do nothing at all
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.start  = 1'b1;
            bus.cancel = 1'b1;
            bus.op     = (k == 0) ? MD_MTHI : MD_MULTU;
            bus.a      = 32'hDEAD_BEEF;
            bus.b      = 32'd9;
            @(posedge clk);
            #1;
            bus.start  = 1'b0;
            bus.cancel = 1'b0;
            vectors++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL start_cancel%0d_idle: got busy %b done %b expected 0 0", k, bus.busy, bus.done);
            end
            vectors++;
            if (bus.hi !== model_hi || bus.lo !== model_lo) begin
                miscompares++;
                $display("[TB] FAIL start_cancel%0d_hilo: got %h/%h expected %h/%h", k, bus.hi, bus.lo, model_hi, model_lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        issue(MD_MTHI, 32'hA5A5_0001, 32'h0, lat, bc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'hFFFF_FFF9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_ctrl: got busy %b done %b expected 0 0", bus.busy, bus.done);
        end
        vectors++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        model_hi = '0;
        model_lo = '0;
        issue(MD_MULTU, 32'd2, 32'd3, lat, bc);
        vectors++;
        if (bus.lo !== 32'd6 || bus.hi !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL postreset_result: got %h/%h expected 00000000/00000006", bus.hi, bus.lo);
        end
        vectors++;
        if (lat != WIDTH + 1) begin miscompares++; $display("[TB] FAIL postreset_latency: got %0d expected %0d", lat, WIDTH + 1); end
        model_lo = 32'd6;
    endtask

    task automatic test_random(input int n, input string tag);
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        int lat, bc, el;
        for (int i = 0; i < n; i++) begin
            op  = 3'($urandom_range(0, 5));
            a   = rand_operand();
            b   = rand_operand();
            exp = ref_result(op, a, b, model_hi, model_lo);
            el  = exp_lat(op, a, b);
            issue(op, a, b, lat, bc);
            model_hi = exp[63:32];
            model_lo = exp[31:0];
            vectors++;
            if (bus.hi !== model_hi) begin
                miscompares++;
                $display("[TB] FAIL %s%0d_hi: op %0d a %h b %h got %h expected %h", tag, i, op, a, b, bus.hi, model_hi);
            end
            vectors++;
            if (bus.lo !== model_lo) begin
                miscompares++;
                $display("[TB] FAIL %s%0d_lo: op %0d a %h b %h got %h expected %h", tag, i, op, a, b, bus.lo, model_lo);
            end
            vectors++;
            if (lat != el || bc != el) begin
                miscompares++;
                $display("[TB] FAIL %s%0d_timing: op %0d got lat %0d busy %0d expected %0d", tag, i, op, lat, bc, el);
            end
        end
    endtask

    // Each issue starts in the cycle the previous done is still high.
    task automatic test_back_to_back();
        test_random(6, "b2b");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_mt_cancel();
        test_drop_start();
        test_reset_mid();
        @(posedge clk);
        #1;
        test_random(40, "rand");
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
